// File: rtl/frame_draw_sequencer.sv
// Full-screen redraw sequencer: walks the frame ROM in raster order and plots into the VGA adapter.
// Optional build macro SKIP_BLACK_EN: black pixels (iColour == 3'b000) are not plotted.
module frame_draw_sequencer #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int ADDR_W  = 15,
  parameter int ROM_LAT = 1
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [2:0]        iState,
  input  logic              iRedraw,
  output logic [2:0]        oFrameSel,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [2:0]        iColour,
  output logic [7:0]        oX,
  output logic [6:0]        oY,
  output logic [2:0]        oColour,
  output logic              oPlot,
  output logic              oBusy,
  output logic              oDone
);

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [7:0]        LAST_X     = 8'(H_RES - 1);
  localparam int                FC_W       = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [FC_W-1:0]   LAST_FLUSH = FC_W'(ROM_LAT - 1);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [2:0]        last_state_q, last_state_d;
  logic [2:0]        frame_sel_q, frame_sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              done_q;
  logic              start, drawing, flush_end;
  logic              state_change, request;

  logic [ROM_LAT-1:0] vld_q;
  logic [7:0]         x_pipe_q [ROM_LAT];
  logic [6:0]         y_pipe_q [ROM_LAT];
  logic               pix_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_q) state_d = DRAW;
      DRAW:    if (addr_q == LAST_ADDR) state_d = FLUSH;
      FLUSH:   if (flush_cnt_q == LAST_FLUSH) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start     = 1'b0;
    drawing   = 1'b0;
    flush_end = 1'b0;
    oBusy     = 1'b0;
    case (state_q)
      IDLE:  start = pending_q;
      DRAW:  begin drawing = 1'b1; oBusy = 1'b1; end
      FLUSH: begin oBusy = 1'b1; flush_end = (flush_cnt_q == LAST_FLUSH); end
      default: ;
    endcase
  end

  // A redraw before any valid state has been seen has no frame to show, so it is ignored.
  assign state_change = (iState != last_state_q) && (iState != 3'd7);
  assign request      = state_change || (iRedraw && (last_state_q != 3'd7));

  always_comb begin
    pending_d    = pending_q;
    last_state_d = last_state_q;
    frame_sel_d  = frame_sel_q;
    if (start) begin
      pending_d   = 1'b0;
      frame_sel_d = last_state_q;
    end
    if (request)      pending_d    = 1'b1;
    if (state_change) last_state_d = iState;
  end

  always_comb begin
    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    if (drawing) begin
      if (addr_q == LAST_ADDR) begin
        addr_d = '0;
        x_d    = '0;
        y_d    = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        if (x_q == LAST_X) begin
          x_d = '0;
          y_d = y_q + 7'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
      end
    end
  end

  assign flush_cnt_d = (state_q == FLUSH && !flush_end) ? flush_cnt_q + FC_W'(1) : '0;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      pending_q    <= 1'b0;
      last_state_q <= 3'd7;
      frame_sel_q  <= '0;
      addr_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      flush_cnt_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      last_state_q <= last_state_d;
      frame_sel_q  <= frame_sel_d;
      addr_q       <= addr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      flush_cnt_q  <= flush_cnt_d;
      done_q       <= flush_end;
    end
  end

  // Coordinates travel alongside the ROM read so they meet iColour in the same cycle.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      // NOTE: the alignment pipeline is reset so an aborted frame cannot emit a stale plot.
      vld_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        x_pipe_q[i] <= '0;
        y_pipe_q[i] <= '0;
      end
    end else begin
      vld_q[0]    <= drawing;
      x_pipe_q[0] <= x_q;
      y_pipe_q[0] <= y_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_q[i]    <= vld_q[i-1];
        x_pipe_q[i] <= x_pipe_q[i-1];
        y_pipe_q[i] <= y_pipe_q[i-1];
      end
    end
  end

  assign pix_valid = vld_q[ROM_LAT-1];

`ifdef SKIP_BLACK_EN
  assign oPlot = pix_valid && (iColour != 3'b000);
`else
  assign oPlot = pix_valid;
`endif

  assign oColour   = pix_valid ? iColour : 3'b000;
  assign oX        = x_pipe_q[ROM_LAT-1];
  assign oY        = y_pipe_q[ROM_LAT-1];
  assign oAddress  = addr_q;
  assign oFrameSel = frame_sel_q;
  assign oDone     = done_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Directed self-checking bench for frame_draw_sequencer with a 1-clock ROM model and a plot monitor.
module tb_frame_draw_sequencer;

  localparam int FRAME_PIX = 19200;
  localparam int DONE_OFS  = 19201;  // first DRAW cycle to oDone: 19200 addresses + 1 flush
`ifdef SKIP_BLACK_EN
  localparam int SKIP_PLOTS = 9600;
`else
  localparam int SKIP_PLOTS = 19200;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  state = 3'd0;
  logic        redraw = 1'b0;
  logic [2:0]  rom_colour = 3'd0;
  bit          rom_mode = 1'b0;

  logic [2:0]  frame_sel;
  logic [14:0] address;
  logic [7:0]  px_x;
  logic [6:0]  px_y;
  logic [2:0]  px_colour;
  logic        plot, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  frame_draw_sequencer dut (
    .iClock   (clk),
    .iReset   (rst),
    .iState   (state),
    .iRedraw  (redraw),
    .oFrameSel(frame_sel),
    .oAddress (address),
    .iColour  (rom_colour),
    .oX       (px_x),
    .oY       (px_y),
    .oColour  (px_colour),
    .oPlot    (plot),
    .oBusy    (busy),
    .oDone    (done)
  );

  function automatic logic [2:0] rom_f(input int a, input bit m);
    if (m) return a[0] ? 3'd5 : 3'd0;
    return 3'((a % 7) + 1);
  endfunction

  always @(posedge clk) rom_colour <= rom_f(int'(address), rom_mode);

  // Plot monitor / scoreboard
  int cyc = 0, plot_cnt, bad_cnt, done_cnt = 0, done_wide, starts, sel_err;
  int last_x, last_y, done_cyc, done_sel, start_cyc, start_sel, first_plot_cyc;
  int bad_n, bad_x, bad_y, exp_next = 0, prev_addr = 0;
  bit prev_busy = 0, prev_done = 0;
  int sel_log[$];

  always @(negedge clk) begin
    int n;
    cyc++;
    if (plot === 1'b1) begin
      n = prev_addr;
      if (!prev_busy || px_x !== 8'(n % 160) || px_y !== 7'(n / 160) ||
          px_colour !== rom_f(n, rom_mode) || (n != 0 && rom_mode == 0 && n != exp_next)) begin
        if (bad_cnt == 0) begin bad_n = n; bad_x = px_x; bad_y = px_y; end
        bad_cnt++;
      end
      if (first_plot_cyc < 0) first_plot_cyc = cyc;
      exp_next = n + 1;
      plot_cnt++;
      last_x = px_x;
      last_y = px_y;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (prev_done || busy) done_wide++;
      done_cyc = cyc;
      done_sel = frame_sel;
    end
    if (busy === 1'b1 && !prev_busy) begin
      starts++;
      start_cyc = cyc;
      start_sel = frame_sel;
      sel_log.push_back(int'(frame_sel));
    end
    if (busy === 1'b1 && prev_busy && frame_sel != start_sel) sel_err++;
    prev_addr = int'(address);
    prev_busy = (busy === 1'b1);
    prev_done = (done === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    plot_cnt = 0; bad_cnt = 0; done_wide = 0; starts = 0; sel_err = 0;
    first_plot_cyc = -1; start_sel = -1; done_sel = -1; last_x = -1; last_y = -1;
    sel_log.delete();
  endtask

  task automatic wait_done(input string tag);
    int d0, k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < 25000) begin tick(); k++; end
    n_tests++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL %s: oDone not seen within 25000 cycles", tag);
    end
  endtask

  task automatic wait_addr(input int target, input string tag);
    int k;
    k = 0;
    while (int'(address) != target && k < 25000) begin tick(); k++; end
    n_tests++;
    if (int'(address) != target) begin
      n_fail++;
      $display("FAIL %s: oAddress=%0d, wanted %0d", tag, address, target);
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++;
    if ({plot, busy, done, address, px_x, px_y, px_colour, frame_sel} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: plot=%b busy=%b done=%b addr=%0d x=%0d y=%0d col=%0d sel=%0d, all must be 0",
               plot, busy, done, address, px_x, px_y, px_colour, frame_sel);
    end
  endtask

  task automatic test_first_frame();
    clear_stats();
    rst = 1'b0;
    wait_done("first_done");
    n_tests++;
    if (plot_cnt !== FRAME_PIX) begin n_fail++; $display("FAIL first_plots: got %0d, want %0d", plot_cnt, FRAME_PIX); end
    n_tests++;
    if (bad_cnt !== 0) begin n_fail++; $display("FAIL first_pixels: %0d bad, first at n=%0d x=%0d y=%0d", bad_cnt, bad_n, bad_x, bad_y); end
    n_tests++;
    if (first_plot_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL first_latency: plot cycle %0d, want %0d", first_plot_cyc, start_cyc + 1); end
    n_tests++;
    if (last_x !== 159 || last_y !== 119) begin n_fail++; $display("FAIL first_last_xy: got %0d,%0d want 159,119", last_x, last_y); end
    n_tests++;
    if (done_cyc - start_cyc !== DONE_OFS) begin n_fail++; $display("FAIL first_done_time: got %0d, want %0d", done_cyc - start_cyc, DONE_OFS); end
    n_tests++;
    if (done_sel !== 0) begin n_fail++; $display("FAIL first_sel: got %0d, want 0", done_sel); end
    tick(); tick();
    n_tests++;
    if (busy !== 1'b0 || done_wide !== 0 || starts !== 1) begin
      n_fail++;
      $display("FAIL first_end: busy=%b done_wide=%0d starts=%0d, want 0,0,1", busy, done_wide, starts);
    end
  endtask

  task automatic test_steady_idle();
    clear_stats();
    repeat (200) tick();
    n_tests++;
    if (plot_cnt !== 0 || starts !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL steady_idle: plots=%0d starts=%0d busy=%b, want 0,0,0", plot_cnt, starts, busy);
    end
  endtask

  task automatic test_state_change_mid_frame();
    int first_done;
    clear_stats();
    state = 3'd1;
    wait_addr(5000, "chg_addr5000");
    state = 3'd2;
    wait_addr(9000, "chg_addr9000");
    state = 3'd3;
    wait_done("chg_done1");
    first_done = done_cyc;
    n_tests++;
    if (done_sel !== 1 || plot_cnt !== FRAME_PIX) begin
      n_fail++;
      $display("FAIL chg_frame1: sel=%0d plots=%0d, want 1,%0d", done_sel, plot_cnt, FRAME_PIX);
    end
    wait_done("chg_done2");
    n_tests++;
    if (done_sel !== 3) begin n_fail++; $display("FAIL chg_frame2_sel: got %0d, want 3", done_sel); end
    n_tests++;
    if (sel_log.size() != 2 || sel_log[0] != 1 || sel_log[1] != 3) begin
      n_fail++;
      $display("FAIL chg_sequence: %0d frames started, want exactly frames 1 then 3", sel_log.size());
    end
    n_tests++;
    if (start_cyc !== first_done + 1) begin n_fail++; $display("FAIL chg_restart: start %0d, want %0d", start_cyc, first_done + 1); end
    n_tests++;
    if (plot_cnt !== 2 * FRAME_PIX || bad_cnt !== 0 || sel_err !== 0) begin
      n_fail++;
      $display("FAIL chg_content: plots=%0d bad=%0d sel_err=%0d, want %0d,0,0", plot_cnt, bad_cnt, sel_err, 2 * FRAME_PIX);
    end
  endtask

  task automatic test_invalid_state();
    clear_stats();
    state = 3'd7;
    repeat (100) tick();
    n_tests++;
    if (starts !== 0 || frame_sel !== 3'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_state: starts=%0d sel=%0d busy=%b, want 0,3,0", starts, frame_sel, busy);
    end
    state = 3'd3;
    repeat (50) tick();
    n_tests++;
    if (starts !== 0 || plot_cnt !== 0) begin
      n_fail++;
      $display("FAIL invalid_return: starts=%0d plots=%0d, want 0,0", starts, plot_cnt);
    end
  endtask

  task automatic test_redraw_and_reset();
    int p0;
    clear_stats();
    redraw = 1'b1;
    tick();
    redraw = 1'b0;
    wait_addr(10000, "redraw_addr10000");
    n_tests++;
    if (starts !== 1 || start_sel !== 3) begin
      n_fail++;
      $display("FAIL redraw_start: starts=%0d sel=%0d, want 1,3", starts, start_sel);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({plot, busy, done, px_x, px_y, address} !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: plot=%b busy=%b done=%b x=%0d y=%0d addr=%0d, all must be 0",
               plot, busy, done, px_x, px_y, address);
    end
    p0 = plot_cnt;
    state    = 3'd4;
    rom_mode = 1'b1;
    repeat (5) tick();
    n_tests++;
    if (plot_cnt !== p0) begin n_fail++; $display("FAIL reset_quiet: %0d plots in reset, want 0", plot_cnt - p0); end
    clear_stats();
    rst = 1'b0;
    wait_done("skip_done");
    n_tests++;
    if (starts !== 1 || done_sel !== 4) begin
      n_fail++;
      $display("FAIL fresh_frame: starts=%0d sel=%0d, want 1,4", starts, done_sel);
    end
    n_tests++;
    if (plot_cnt !== SKIP_PLOTS || bad_cnt !== 0) begin
      n_fail++;
      $display("FAIL skip_plots: plots=%0d bad=%0d, want %0d,0", plot_cnt, bad_cnt, SKIP_PLOTS);
    end
    n_tests++;
    if (done_cyc - start_cyc !== DONE_OFS) begin n_fail++; $display("FAIL skip_done_time: got %0d, want %0d", done_cyc - start_cyc, DONE_OFS); end
    n_tests++;
    if (last_x !== 159 || last_y !== 119) begin n_fail++; $display("FAIL skip_last_xy: got %0d,%0d want 159,119", last_x, last_y); end
    repeat (50) tick();
    n_tests++;
    if (starts !== 1 || busy !== 1'b0 || done_wide !== 0) begin
      n_fail++;
      $display("FAIL skip_end: starts=%0d busy=%b done_wide=%0d, want 1,0,0", starts, busy, done_wide);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_steady_idle();
    test_state_change_mid_frame();
    test_invalid_state();
    test_redraw_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
